// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the FIFO-to-AXI-Stream read adapter.
//   FIFO_B_DEF  : default stream data width (bits)
//   FIFO_LW_DEF : default width of the packet-length input / beat index
//   BEAT_CNT_W  : width of the free-running accepted-beat counter
//   occ_after() : buffer occupancy once this cycle's pop and the word
//                 already in flight from the FIFO have both settled
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned FIFO_B_DEF  = 16;
   localparam int unsigned FIFO_LW_DEF = 16;
   localparam int unsigned BEAT_CNT_W  = 32;

   // cnt is 0..2 and pop can only be 1 when cnt > 0, so the result stays
   // within 0..3 and never underflows.
   function automatic logic [2:0] occ_after(input logic [1:0] cnt,
                                            input logic       pend,
                                            input logic       pop);
      return {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/axis_skid2.sv
// -----------------------------------------------------------------------------
// axis_skid2
// Two-entry output buffer. Words written with in_valid land at the tail;
// the head is presented on out_data whenever the buffer is non-empty.
// A push and a pop in the same cycle leave the occupancy unchanged: the
// head advances and the new word takes the freed slot.
// The writer is responsible for never pushing into a full buffer unless a
// pop happens in that same cycle.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset (empties the buffer)
//   in_valid  in   write strobe for in_data
//   in_data   in   W  word to append at the tail
//   out_valid out  buffer non-empty
//   out_ready in   consumer accepts the head this cycle
//   out_data  out  W  head word
//   occ       out  2  current occupancy (0..2)
// -----------------------------------------------------------------------------
module axis_skid2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occ
);

   logic [W-1:0] mem_reg [0:1];
   logic         rd_ptr_reg;
   logic         wr_ptr_reg;
   logic [1:0]   cnt_reg;
   logic [1:0]   cnt_next;
   logic         push;
   logic         pop;

   assign push = in_valid;
   assign pop  = out_valid && out_ready;

   always_comb begin
      cnt_next = cnt_reg;
      case ({push, pop})
         2'b10:   cnt_next = cnt_reg + 2'd1;
         2'b01:   cnt_next = cnt_reg - 2'd1;
         default: cnt_next = cnt_reg;
      endcase
   end

   // With two slots and one-bit pointers, a push while full (only legal
   // together with a pop) writes exactly the slot the head is leaving.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         cnt_reg    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= in_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         cnt_reg <= cnt_next;
      end
   end

   assign out_valid = (cnt_reg != 2'd0);
   assign out_data  = mem_reg[rd_ptr_reg];
   assign occ       = cnt_reg;

endmodule

// File: rtl/fifo_rd_axis.sv
// -----------------------------------------------------------------------------
// fifo_rd_axis
// Drains a first-word-fall-through-less FIFO (data valid the cycle after the
// read strobe) into an AXI-Stream master. A read is issued only when the
// two-entry output buffer is guaranteed a free slot for the returning word,
// so the stream can run at one beat per clock with tready held high.
// tlast is generated from a packet-length input latched at each packet's
// first beat; a free-running counter tallies every accepted beat.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   fifo_dout      in   B   FIFO read data (valid the cycle after fifo_rd_en)
//   fifo_empty     in   FIFO empty flag
//   fifo_rd_en     out  FIFO read strobe
//   pkt_len        in   LW  beats per packet, 0 = never assert tlast
//   m_axis_tdata   out  B   stream data
//   m_axis_tvalid  out  stream valid
//   m_axis_tready  in   stream ready
//   m_axis_tlast   out  last beat of a packet
//   beat_cnt       out  32  accepted beats since reset (wraps)
// -----------------------------------------------------------------------------
module fifo_rd_axis
   import fifo_pkg::*;
#(
   parameter int B  = FIFO_B_DEF,
   parameter int LW = FIFO_LW_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [B-1:0]          fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [LW-1:0]         pkt_len,
   output logic [B-1:0]          m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [BEAT_CNT_W-1:0] beat_cnt
);

   logic                  pend_reg;
   logic                  skid_valid;
   logic [B:0]            skid_data;
   logic [1:0]            skid_cnt;
   logic                  pop;
   logic [2:0]            occ_next;
   logic [LW-1:0]         beat_idx_reg;
   logic [LW-1:0]         len_reg;
   logic [LW-1:0]         cur_len;
   logic                  is_last;
   logic [BEAT_CNT_W-1:0] beat_cnt_reg;

   // ---------------------------------------------------------------------
   // Read issue: only request a word if, after this cycle's pop, the word
   // already in flight plus the new one still fit in the two slots.
   // ---------------------------------------------------------------------
   assign pop      = m_axis_tvalid && m_axis_tready;
   assign occ_next = occ_after(skid_cnt, pend_reg, pop);

   always_comb begin
      fifo_rd_en = 1'b0;
      if (!rst && !fifo_empty && (occ_next < 3'd2)) begin
         fifo_rd_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_reg <= 1'b0;
      end else begin
         pend_reg <= fifo_rd_en;
      end
   end

   // The extra top bit marks a slot as holding a real captured word, so an
   // empty or just-reset slot can never leak old contents onto tdata.
   axis_skid2 #(
      .W (B + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pend_reg),
      .in_data   ({1'b1, fifo_dout}),
      .out_valid (skid_valid),
      .out_ready (m_axis_tready),
      .out_data  (skid_data),
      .occ       (skid_cnt)
   );

   // Outputs are forced idle while reset is held, not only after the edge.
   assign m_axis_tvalid = skid_valid && !rst;
   assign m_axis_tdata  = (m_axis_tvalid && skid_data[B]) ? skid_data[B-1:0] : '0;

   // ---------------------------------------------------------------------
   // Packet framing. At beat index 0 the live pkt_len is used (and latched
   // on the pop); later beats use the latched copy so a mid-packet change
   // only affects the following packet.
   // ---------------------------------------------------------------------
   assign cur_len = (beat_idx_reg == '0) ? pkt_len : len_reg;
   assign is_last = (cur_len != '0) && (beat_idx_reg == (cur_len - LW'(1)));

   assign m_axis_tlast = m_axis_tvalid && is_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_idx_reg <= '0;
         len_reg      <= '0;
      end else if (pop) begin
         if (beat_idx_reg == '0) begin
            len_reg <= pkt_len;
         end
         if (is_last) begin
            beat_idx_reg <= '0;
         end else begin
            beat_idx_reg <= beat_idx_reg + LW'(1);
         end
      end
   end

   // Only written on reset or pop, so the count holds exactly between beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_reg <= '0;
      end else if (pop) begin
         beat_cnt_reg <= beat_cnt_reg + BEAT_CNT_W'(1);
      end
   end

   assign beat_cnt = beat_cnt_reg;

endmodule

// File: tb/tb_fifo_rd_axis.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_axis
// Directed stimulus with a scoreboard: every word loaded into the FIFO model
// also pushes its expected data/tlast into exp_q; an independent monitor pops
// and compares on each accepted beat, and also watches stall stability, reads
// while empty and the number of words outstanding.
// -----------------------------------------------------------------------------
module tb_fifo_rd_axis;
   import fifo_pkg::*;

   localparam int B  = 16;
   localparam int LW = 16;

   typedef struct {
      logic [B-1:0] d;
      logic         l;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [B-1:0]          fifo_dout = '0;
   logic                  fifo_empty = 1'b1;
   logic                  fifo_rd_en;
   logic [LW-1:0]         pkt_len;
   logic [B-1:0]          m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;
   logic [BEAT_CNT_W-1:0] beat_cnt;

   logic [B-1:0] fifo_q [$];
   exp_t         exp_q  [$];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fifo_rd_axis #(
      .B  (B),
      .LW (LW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_dout     (fifo_dout),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .pkt_len       (pkt_len),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .beat_cnt      (beat_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_word(input logic [B-1:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      fifo_q.push_back(d);
      exp_q.push_back(e);
      fifo_empty = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk(name, exp_q.size(), 0);
   endtask

   // FIFO model: data appears the cycle after the read strobe; owner reset
   // clears it.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            fifo_q.delete();
            fifo_empty <= 1'b1;
         end else if (fifo_rd_en) begin
            if (fifo_q.size() != 0) begin
               fifo_dout <= fifo_q.pop_front();
            end
            fifo_empty <= (fifo_q.size() == 0);
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic         prev_stall;
      logic [B-1:0] prev_d;
      logic         prev_l;
      int           issued;
      int           popped;
      exp_t         e;
      prev_stall = 1'b0;
      prev_d     = '0;
      prev_l     = 1'b0;
      issued     = 0;
      popped     = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
            issued     = 0;
            popped     = 0;
         end else begin
            if (prev_stall) begin
               chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                   {1'b1, prev_l, prev_d});
            end
            if (fifo_rd_en) begin
               chk("rd_while_empty", fifo_empty, 0);
               issued++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
               popped++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", m_axis_tdata, 64'hDEAD);
               end else begin
                  e = exp_q.pop_front();
                  $display("beat data=0x%0h tlast=%0b exp_data=0x%0h exp_tlast=%0b",
                           m_axis_tdata, m_axis_tlast, e.d, e.l);
                  chk("beat_data", m_axis_tdata, e.d);
                  chk("beat_tlast", m_axis_tlast, e.l);
               end
            end
            if (fifo_rd_en) begin
               chk("outstanding_le_3", (issued - popped) <= 3, 1);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [BEAT_CNT_W-1:0] wrap_exp [3];
      logic                  seen;
      rst           = 1'b1;
      m_axis_tready = 1'b1;
      pkt_len       = '0;

      // ---- reset state and idle after release with an empty FIFO ----
      tick();
      tick();
      #1;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         #1;
         chk("idle_outputs", {fifo_rd_en, m_axis_tvalid, m_axis_tlast, beat_cnt}, 0);
      end

      // ---- latency and full-rate streaming, pkt_len = 0 ----
      tick();
      for (int i = 1; i <= 8; i++) push_word(B'(i), 1'b0);
      #1;
      chk("lat_rd_en_t", fifo_rd_en, 1);
      chk("lat_tvalid_t", m_axis_tvalid, 0);
      tick();
      #1;
      chk("lat_tvalid_t1", m_axis_tvalid, 0);
      tick();
      #1;
      chk("lat_tvalid_t2", m_axis_tvalid, 1);
      chk("first_data", m_axis_tdata, 1);
      for (int i = 0; i < 7; i++) begin
         tick();
         #1;
         chk("sustain_tvalid", m_axis_tvalid, 1);
      end
      wait_drain("drain_stream");
      tick();
      tick();
      #1;
      chk("stream_beat_cnt", beat_cnt, 8);
      chk("stream_idle_tvalid", m_axis_tvalid, 0);

      // ---- backpressure 1,0,0,1 ----
      do_reset(2);
      for (int i = 0; i < 8; i++) push_word(B'(16'h31 + i), 1'b0);
      for (int c = 0; c < 80; c++) begin
         m_axis_tready = ((c % 4) == 0) || ((c % 4) == 3);
         if (exp_q.size() == 0) break;
         tick();
      end
      m_axis_tready = 1'b1;
      wait_drain("drain_bp");
      tick();
      tick();
      #1;
      chk("bp_beat_cnt", beat_cnt, 8);

      // ---- packet framing with mid-packet length change ----
      do_reset(2);
      pkt_len = LW'(3);
      push_word(16'h11, 1'b0);
      push_word(16'h12, 1'b0);
      push_word(16'h13, 1'b1);
      push_word(16'h14, 1'b0);
      push_word(16'h15, 1'b0);
      push_word(16'h16, 1'b1);
      push_word(16'h17, 1'b0);
      push_word(16'h18, 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (beat_cnt == 4) begin
            pkt_len = LW'(2);
            seen    = 1'b1;
            break;
         end
      end
      chk("pkt_len_switch_point", seen, 1);
      wait_drain("drain_pkt");
      pkt_len = '0;

      // ---- reset with words buffered and in flight ----
      do_reset(2);
      m_axis_tready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(B'(16'h21 + i), 1'b0);
      repeat (5) tick();
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_rd_en", fifo_rd_en, 0);
      chk("midrst_tvalid", m_axis_tvalid, 0);
      chk("midrst_tdata", m_axis_tdata, 0);
      tick();
      #1;
      chk("midrst_beat_cnt", beat_cnt, 0);
      chk("midrst_tvalid_after", m_axis_tvalid, 0);
      tick();
      rst = 1'b0;
      m_axis_tready = 1'b1;
      push_word(16'h000A, 1'b0);
      push_word(16'h000B, 1'b0);
      wait_drain("drain_refill");
      tick();
      tick();
      #1;
      chk("refill_beat_cnt", beat_cnt, 2);

      // ---- beat_cnt wrap ----
      do_reset(2);
      tick();
      force dut.beat_cnt_reg = 32'hFFFF_FFFE;
      tick();
      release dut.beat_cnt_reg;
      push_word(16'h41, 1'b0);
      push_word(16'h42, 1'b0);
      push_word(16'h43, 1'b0);
      wrap_exp[0] = 32'hFFFF_FFFF;
      wrap_exp[1] = 32'h0000_0000;
      wrap_exp[2] = 32'h0000_0001;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (m_axis_tvalid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk("wrap_first_valid", seen, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         #1;
         chk("wrap_beat_cnt", beat_cnt, wrap_exp[k]);
      end
      wait_drain("drain_wrap");

      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
